// File: rtl/bus_mux_pkg.sv
// bus_mux_pkg: shared state encoding, slave limit and priority helper for the response mux.
package bus_mux_pkg;
  localparam int MAX_SLAVES = 8;
  typedef enum logic [1:0] {IDLE, ACTIVE, UNMAPPED} busState;
  function automatic logic [MAX_SLAVES-1:0] lowestOneHot(input logic [MAX_SLAVES-1:0] hits);
    return hits & (~hits + 1'b1);
  endfunction
endpackage

// File: rtl/bus_slave_response_mux_if.sv
// bus_slave_response_mux_if: master request, per-slave responses and muxed response of the shared bus.
interface bus_slave_response_mux_if #(parameter int NUM_SLAVES = 2);
  logic beginTransactionIn;
  logic endTransactionIn;
  logic [31:0] addressDataIn;
  logic [NUM_SLAVES-1:0] slaveEndTransactionIn;
  logic [NUM_SLAVES-1:0] slaveDataValidIn;
  logic [NUM_SLAVES-1:0] slaveBusyIn;
  logic [NUM_SLAVES-1:0] slaveBusErrorIn;
  logic [32*NUM_SLAVES-1:0] slaveAddressDataIn;
  logic endTransactionOut;
  logic dataValidOut;
  logic busyOut;
  logic busErrorOut;
  logic [31:0] addressDataOut;
  logic [NUM_SLAVES-1:0] activeSlaveOut;
  logic timeoutOut;
  modport slave (
    input beginTransactionIn, endTransactionIn, addressDataIn, slaveEndTransactionIn,
          slaveDataValidIn, slaveBusyIn, slaveBusErrorIn, slaveAddressDataIn,
    output endTransactionOut, dataValidOut, busyOut, busErrorOut, addressDataOut,
           activeSlaveOut, timeoutOut
  );
  modport master (
    output beginTransactionIn, endTransactionIn, addressDataIn, slaveEndTransactionIn,
           slaveDataValidIn, slaveBusyIn, slaveBusErrorIn, slaveAddressDataIn,
    input endTransactionOut, dataValidOut, busyOut, busErrorOut, addressDataOut,
          activeSlaveOut, timeoutOut
  );
endinterface

// File: rtl/bus_addr_decoder.sv
// bus_addr_decoder: masked window compare per slave; lowest-index hit wins on overlap.
module bus_addr_decoder
  import bus_mux_pkg::*;
#(
  parameter int NUM_SLAVES = 2,
  parameter logic [32*NUM_SLAVES-1:0] BASE_ADDRESSES = {32'h04000000, 32'h00000000},
  parameter logic [32*NUM_SLAVES-1:0] ADDRESS_MASKS = {32'hFF000000, 32'hFC000000}
) (
  input  logic [31:0] address,
  output logic [NUM_SLAVES-1:0] hit,
  output logic [NUM_SLAVES-1:0] winner
);
  for (genvar i = 0; i < NUM_SLAVES; i++) begin : gHit
    assign hit[i] = (address & ADDRESS_MASKS[32*i+:32]) == BASE_ADDRESSES[32*i+:32];
  end
  assign winner = NUM_SLAVES'(lowestOneHot(MAX_SLAVES'(hit)));
endmodule

// File: rtl/bus_slave_response_mux.sv
// bus_slave_response_mux: latches the decoded owner and forwards its responses, registered.
// Define BUS_MUX_TIMEOUT_EN to add the stall watchdog (TIMEOUT_CYCLES idle owner cycles -> bus error).
module bus_slave_response_mux
  import bus_mux_pkg::*;
#(
  parameter int NUM_SLAVES = 2,
  parameter logic [32*NUM_SLAVES-1:0] BASE_ADDRESSES = {32'h04000000, 32'h00000000},
  parameter logic [32*NUM_SLAVES-1:0] ADDRESS_MASKS = {32'hFF000000, 32'hFC000000},
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic clock,
  input logic reset,
  bus_slave_response_mux_if.slave bus
);
  if (NUM_SLAVES < 1 || NUM_SLAVES > MAX_SLAVES || TIMEOUT_CYCLES < 2) begin : gBadConfig
    $error("bus_slave_response_mux: unsupported NUM_SLAVES or TIMEOUT_CYCLES");
  end
  busState state, stateNext;
  logic [NUM_SLAVES-1:0] hit, winner, owner;
  logic active, ownEnd, ownValid, ownBusy, ownError, expire;
  logic [31:0] ownData;
  bus_addr_decoder #(
    .NUM_SLAVES(NUM_SLAVES),
    .BASE_ADDRESSES(BASE_ADDRESSES),
    .ADDRESS_MASKS(ADDRESS_MASKS)
  ) decoder (
    .address(bus.addressDataIn),
    .hit(hit),
    .winner(winner)
  );
  // owner is zero outside ACTIVE, so the masked reductions already silence idle slaves
  assign active = state == ACTIVE;
  assign ownEnd = |(owner & bus.slaveEndTransactionIn);
  assign ownValid = |(owner & bus.slaveDataValidIn);
  assign ownBusy = |(owner & bus.slaveBusyIn);
  assign ownError = |(owner & bus.slaveBusErrorIn);
  assign bus.activeSlaveOut = owner;
  always_comb begin
    ownData = '0;
    for (int i = 0; i < NUM_SLAVES; i++) ownData |= owner[i] ? bus.slaveAddressDataIn[32*i+:32] : 32'd0;
  end
`ifdef BUS_MUX_TIMEOUT_EN
  localparam int COUNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
  logic [COUNT_WIDTH-1:0] count;
  // an owner end or error on the expiry cycle wins over the watchdog
  assign expire = active && !(ownValid || ownBusy || ownEnd || ownError) &&
                  count == COUNT_WIDTH'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clock or posedge reset)
    if (reset) count <= '0;
    else count <= (active && !ownValid && !ownBusy) ? count + 1'b1 : '0;
`else
  assign expire = 1'b0;
`endif
  always_comb begin
    stateNext = state;
    if (state == IDLE) stateNext = bus.beginTransactionIn ? (|hit ? ACTIVE : UNMAPPED) : IDLE;
    else if (state == UNMAPPED) stateNext = IDLE;
    else if (ownEnd || ownError || bus.endTransactionIn || expire) stateNext = IDLE;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= IDLE;
      owner <= '0;
      bus.endTransactionOut <= 1'b0;
      bus.dataValidOut <= 1'b0;
      bus.busyOut <= 1'b0;
      bus.busErrorOut <= 1'b0;
      bus.addressDataOut <= '0;
      bus.timeoutOut <= 1'b0;
    end else begin
      state <= stateNext;
      owner <= stateNext != ACTIVE ? '0 : state == IDLE ? winner : owner;
      bus.endTransactionOut <= ownEnd;
      bus.dataValidOut <= ownValid;
      bus.busyOut <= ownBusy;
      bus.busErrorOut <= ownError || state == UNMAPPED || expire;
      bus.addressDataOut <= ownValid ? ownData : '0;
      bus.timeoutOut <= expire;
    end
endmodule

// File: tb/tb_bus_slave_response_mux.sv
// tb_bus_slave_response_mux: transaction-level model checked every cycle plus directed literal checks.
module tb_bus_slave_response_mux;
  localparam int N = 2;
  localparam int T = 16;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;
  bus_slave_response_mux_if #(.NUM_SLAVES(N)) bus ();
  bus_slave_response_mux_if #(.NUM_SLAVES(N)) ovl ();
  bus_slave_response_mux #(
    .NUM_SLAVES(N),
    .BASE_ADDRESSES({32'h04000000, 32'h00000000}),
    .ADDRESS_MASKS({32'hFF000000, 32'hFC000000}),
    .TIMEOUT_CYCLES(T)
  ) dut (.clock(clock), .reset(reset), .bus(bus));
  bus_slave_response_mux #(
    .NUM_SLAVES(N),
    .BASE_ADDRESSES({32'h04000000, 32'h00000000}),
    .ADDRESS_MASKS({32'hFF000000, 32'hF8000000}),
    .TIMEOUT_CYCLES(T)
  ) ovlDut (.clock(clock), .reset(reset), .bus(ovl));

  int checks = 0;
  int fails = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  logic [31:0] base [N] = '{32'h00000000, 32'h04000000};
  logic [31:0] mask [N] = '{32'hFC000000, 32'hFF000000};
  function automatic int decode(input logic [31:0] a);
    for (int i = 0; i < N; i++) if ((a & mask[i]) == base[i]) return i;
    return -1;
  endfunction

  // Model: owner index (-1 = none), pending unmapped error, and stall counter.
  int own = -1;
  int win;
  bit unm = 1'b0;
  int cnt = 0;
  logic eEnd, eDv, eBusy, eErr, eTo;
  logic [31:0] eData;
  logic [N-1:0] eAct;
  always @(posedge clock) begin
    {eEnd, eDv, eBusy, eErr, eTo} = '0;
    eData = '0;
    if (reset) begin
      own = -1;
      unm = 1'b0;
      cnt = 0;
    end else if (unm) begin
      eErr = 1'b1;
      unm = 1'b0;
    end else if (own < 0) begin
      if (bus.beginTransactionIn) begin
        win = decode(bus.addressDataIn);
        if (win < 0) unm = 1'b1;
        else begin
          own = win;
          cnt = 0;
        end
      end
    end else begin
      eEnd = bus.slaveEndTransactionIn[own];
      eDv = bus.slaveDataValidIn[own];
      eBusy = bus.slaveBusyIn[own];
      eErr = bus.slaveBusErrorIn[own];
      eData = eDv ? bus.slaveAddressDataIn[32*own+:32] : 32'd0;
`ifdef BUS_MUX_TIMEOUT_EN
      if (eDv || eBusy) cnt = 0;
      else cnt++;
      eTo = cnt >= T && !eEnd && !eErr;
`endif
      eErr = eErr | eTo;
      if (eEnd || eErr || bus.endTransactionIn) own = -1;
    end
    eAct = '0;
    if (own >= 0) eAct[own] = 1'b1;
    #2;
    check("cmp_end", bus.endTransactionOut, eEnd);
    check("cmp_dv", bus.dataValidOut, eDv);
    check("cmp_busy", bus.busyOut, eBusy);
    check("cmp_err", bus.busErrorOut, eErr);
    check("cmp_data", bus.addressDataOut, eData);
    check("cmp_active", bus.activeSlaveOut, eAct);
    check("cmp_timeout", bus.timeoutOut, eTo);
  end

  task automatic cyc();
    @(negedge clock);
  endtask

  task automatic clearSlaves();
    bus.slaveEndTransactionIn = '0;
    bus.slaveDataValidIn = '0;
    bus.slaveBusyIn = '0;
    bus.slaveBusErrorIn = '0;
    bus.slaveAddressDataIn = '0;
  endtask

  initial begin
    bus.beginTransactionIn = 1'b0;
    bus.endTransactionIn = 1'b0;
    bus.addressDataIn = '0;
    clearSlaves();
    ovl.beginTransactionIn = 1'b0;
    ovl.endTransactionIn = 1'b0;
    ovl.addressDataIn = '0;
    ovl.slaveEndTransactionIn = '0;
    ovl.slaveDataValidIn = '0;
    ovl.slaveBusyIn = '0;
    ovl.slaveBusErrorIn = '0;
    ovl.slaveAddressDataIn = '0;
    repeat (2) cyc();
    check("rst_active", bus.activeSlaveOut, 0);
    check("rst_err", bus.busErrorOut, 0);
    check("rst_data", bus.addressDataOut, 0);
    reset = 1'b0;
    cyc();
    // RAM read: four words then slave end
    bus.beginTransactionIn = 1'b1;
    bus.addressDataIn = 32'h00000100;
    cyc();
    bus.beginTransactionIn = 1'b0;
    bus.addressDataIn = '0;
    check("ram_owner", bus.activeSlaveOut, 2'b01);
    for (int k = 0; k < 4; k++) begin
      bus.slaveDataValidIn = 2'b01;
      bus.slaveAddressDataIn = {32'h0, 32'(32'hA0000000 + k)};
      cyc();
      check("ram_dv", bus.dataValidOut, 1);
      check("ram_data", bus.addressDataOut, 32'(32'hA0000000 + k));
    end
    clearSlaves();
    bus.slaveEndTransactionIn = 2'b01;
    cyc();
    check("ram_end", bus.endTransactionOut, 1);
    check("ram_end_dv", bus.dataValidOut, 0);
    check("ram_release", bus.activeSlaveOut, 0);
    clearSlaves();
    cyc();
    check("ram_end_pulse", bus.endTransactionOut, 0);
    // slave chatter while idle is never forwarded
    bus.slaveDataValidIn = 2'b01;
    bus.slaveEndTransactionIn = 2'b01;
    bus.slaveBusyIn = 2'b01;
    bus.slaveAddressDataIn = {32'h0, 32'hDEADBEEF};
    cyc();
    check("idle_dv", bus.dataValidOut, 0);
    check("idle_end", bus.endTransactionOut, 0);
    check("idle_busy", bus.busyOut, 0);
    clearSlaves();
    cyc();
    // unmapped address
    bus.beginTransactionIn = 1'b1;
    bus.addressDataIn = 32'h08000000;
    cyc();
    bus.beginTransactionIn = 1'b0;
    check("unm_err_early", bus.busErrorOut, 0);
    cyc();
    check("unm_err", bus.busErrorOut, 1);
    check("unm_end", bus.endTransactionOut, 0);
    check("unm_active", bus.activeSlaveOut, 0);
    cyc();
    check("unm_err_once", bus.busErrorOut, 0);
    // flash owner with slave 0 chattering and a stray begin
    bus.beginTransactionIn = 1'b1;
    bus.addressDataIn = 32'h04000010;
    cyc();
    check("flash_owner", bus.activeSlaveOut, 2'b10);
    bus.addressDataIn = 32'h00000100;
    bus.slaveDataValidIn = 2'b01;
    bus.slaveAddressDataIn = {32'h0, 32'hDEADBEEF};
    cyc();
    bus.beginTransactionIn = 1'b0;
    check("flash_spur_dv", bus.dataValidOut, 0);
    check("flash_spur_data", bus.addressDataOut, 0);
    check("flash_keep", bus.activeSlaveOut, 2'b10);
    bus.slaveDataValidIn = 2'b11;
    bus.slaveAddressDataIn = {32'h12345678, 32'hDEADBEEF};
    cyc();
    check("flash_dv", bus.dataValidOut, 1);
    check("flash_data", bus.addressDataOut, 32'h12345678);
    bus.slaveDataValidIn = 2'b01;
    bus.slaveEndTransactionIn = 2'b10;
    bus.slaveBusErrorIn = 2'b10;
    cyc();
    check("flash_end", bus.endTransactionOut, 1);
    check("flash_err", bus.busErrorOut, 1);
    check("flash_release", bus.activeSlaveOut, 0);
    clearSlaves();
    cyc();
    check("flash_err_once", bus.busErrorOut, 0);
    // silent owner: watchdog fires only when enabled
    bus.beginTransactionIn = 1'b1;
    bus.addressDataIn = 32'h00000100;
    cyc();
    bus.beginTransactionIn = 1'b0;
`ifdef BUS_MUX_TIMEOUT_EN
    repeat (15) cyc();
    check("to_not_yet", bus.timeoutOut, 0);
    cyc();
    check("to_pulse", bus.timeoutOut, 1);
    check("to_err", bus.busErrorOut, 1);
    check("to_release", bus.activeSlaveOut, 0);
    cyc();
    check("to_once", bus.timeoutOut, 0);
`else
    repeat (24) cyc();
    check("nto_active", bus.activeSlaveOut, 2'b01);
    check("nto_timeout", bus.timeoutOut, 0);
    bus.endTransactionIn = 1'b1;
    cyc();
    bus.endTransactionIn = 1'b0;
    check("nto_release", bus.activeSlaveOut, 0);
`endif
    // busy owner never times out
    bus.beginTransactionIn = 1'b1;
    cyc();
    bus.beginTransactionIn = 1'b0;
    bus.slaveBusyIn = 2'b01;
    repeat (24) begin
      cyc();
      check("busy_no_to", bus.timeoutOut, 0);
    end
    check("busy_out", bus.busyOut, 1);
    check("busy_active", bus.activeSlaveOut, 2'b01);
    clearSlaves();
    bus.endTransactionIn = 1'b1;
    cyc();
    bus.endTransactionIn = 1'b0;
    check("mend_release", bus.activeSlaveOut, 0);
    // asynchronous reset mid-burst
    bus.beginTransactionIn = 1'b1;
    cyc();
    bus.beginTransactionIn = 1'b0;
    for (int k = 0; k < 2; k++) begin
      bus.slaveDataValidIn = 2'b01;
      bus.slaveAddressDataIn = {32'h0, 32'(32'hCAFE0000 + k)};
      cyc();
      check("burst_data", bus.addressDataOut, 32'(32'hCAFE0000 + k));
    end
    bus.slaveAddressDataIn = {32'h0, 32'hCAFE0002};
    @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    check("arst_dv", bus.dataValidOut, 0);
    check("arst_data", bus.addressDataOut, 0);
    check("arst_active", bus.activeSlaveOut, 0);
    check("arst_err", bus.busErrorOut, 0);
    cyc();
    clearSlaves();
    cyc();
    reset = 1'b0;
    bus.beginTransactionIn = 1'b1;
    bus.addressDataIn = 32'h04000000;
    cyc();
    bus.beginTransactionIn = 1'b0;
    check("post_rst_owner", bus.activeSlaveOut, 2'b10);
    bus.endTransactionIn = 1'b1;
    cyc();
    bus.endTransactionIn = 1'b0;
    check("post_rst_release", bus.activeSlaveOut, 0);
    // overlapping windows on the second instance: lowest index wins, stray begin ignored
    ovl.beginTransactionIn = 1'b1;
    ovl.addressDataIn = 32'h04000000;
    cyc();
    check("ovl_owner", ovl.activeSlaveOut, 2'b01);
    cyc();
    ovl.beginTransactionIn = 1'b0;
    check("ovl_keep", ovl.activeSlaveOut, 2'b01);
    ovl.endTransactionIn = 1'b1;
    cyc();
    ovl.endTransactionIn = 1'b0;
    check("ovl_release", ovl.activeSlaveOut, 0);
    cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
